sprite_blit_engine: RTL and testbench

Parametrised sprite datapath for the bomberman VGA path. It holds one sprite's position, colour and direction of motion, and executes four commands issued through a go/op handshake: draw, erase, bounce-step and set-position. Draw and erase scan the SPRITE_W x SPRITE_H rectangle one pixel per clock, emitting x/y/colour/plot to the VGA adapter. It sits between the game control FSM and the VGA adapter.

---
 rtl/sprite_blit_pkg.sv | 20 ++
 rtl/sprite_scan_counter.sv | 57 +++++
 rtl/sprite_blit_engine.sv | 167 ++++++++++++++++
 tb/tb_sprite_blit_engine.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_blit_pkg.sv
// Shared definitions for the sprite blit engine:
// command encodings, FSM states and counter sizing.
package sprite_blit_pkg;

  localparam logic [1:0] OP_DRAW  = 2'd0;
  localparam logic [1:0] OP_ERASE = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_SET   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major col/row scan counter with clear, enable
// and end-of-row / last-pixel flags.
module sprite_scan_counter
  import sprite_blit_pkg::*;
#(
  parameter int W = 4,
  parameter int H = 4,
  localparam int CW = cnt_w(W),
  localparam int RW = cnt_w(H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          last_col_o,
  output logic          last_o
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          last_row;

  assign last_col_o = (col_q == CW'(W - 1));
  assign last_row   = (row_q == RW'(H - 1));
  assign last_o     = last_col_o && last_row;
  assign col_o      = col_q;
  assign row_o      = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (last_col_o) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/sprite_blit_engine.sv
// Sprite datapath: holds position/direction/colour and runs
// draw, erase, bounce-step and set-position commands.
module sprite_blit_engine
  import sprite_blit_pkg::*;
#(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COLOUR_W  = 3,
  parameter int SPRITE_W  = 4,
  parameter int SPRITE_H  = 4,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int BG_COLOUR = 0,
  parameter int X_INIT    = 0,
  parameter int Y_INIT    = 60
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                go,
  input  logic [1:0]          op,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                plot,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      pos_x,
  output logic [Y_W-1:0]      pos_y
);

  localparam int CW = cnt_w(SPRITE_W);
  localparam int RW = cnt_w(SPRITE_H);
  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - SPRITE_W);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - SPRITE_H);
  localparam logic [X_W-1:0] X_RST = X_W'(X_INIT);
  localparam logic [Y_W-1:0] Y_RST = Y_W'(Y_INIT);
  localparam logic [COLOUR_W-1:0] BG = COLOUR_W'(BG_COLOUR);

  state_e state_q, state_d;

  logic [X_W-1:0]      pos_x_q, x_out_q;
  logic [Y_W-1:0]      pos_y_q, y_out_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                dir_x_q, dir_y_q;
  logic                plot_q;

  logic          accept, scan_op, scanning;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          last_col, last_px;
  logic [X_W-1:0] nxt_x, step_x, set_x;
  logic [Y_W-1:0] nxt_y, step_y, set_y;
  logic           ndir_x, ndir_y;

  assign scanning = (state_q == ST_SCAN);
  assign accept   = go && !scanning;
  assign scan_op  = (op == OP_DRAW) || (op == OP_ERASE);

  sprite_scan_counter #(
    .W(SPRITE_W),
    .H(SPRITE_H)
  ) u_cnt (
    .clk       (clock),
    .rst_n     (resetn),
    .clr_i     (accept),
    .en_i      (scanning),
    .col_o     (col),
    .row_o     (row),
    .last_col_o(last_col),
    .last_o    (last_px)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_SCAN: if (last_px) state_d = ST_FINISH;
      default: begin
        if (accept) state_d = scan_op ? ST_SCAN : ST_FINISH;
        else        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      ST_SCAN:   busy = 1'b1;
      ST_FINISH: done = 1'b1;
      default:   ;
    endcase
  end

  // Next pixel in row-major order relative to the sprite origin.
  assign nxt_x = last_col ? pos_x_q
               : pos_x_q + X_W'(col) + X_W'(1);
  assign nxt_y = pos_y_q + Y_W'(row)
               + (last_col ? Y_W'(1) : Y_W'(0));

  // Bounce: flip at the edge before moving.
  assign ndir_x = dir_x_q ? (pos_x_q != X_MAX)
                          : (pos_x_q == '0);
  assign ndir_y = dir_y_q ? (pos_y_q != Y_MAX)
                          : (pos_y_q == '0);
  assign step_x = ndir_x ? pos_x_q + X_W'(1)
                         : pos_x_q - X_W'(1);
  assign step_y = ndir_y ? pos_y_q + Y_W'(1)
                         : pos_y_q - Y_W'(1);

  assign set_x = (x_in > X_MAX) ? X_MAX : x_in;
  assign set_y = (y_in > Y_MAX) ? Y_MAX : y_in;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pos_x_q  <= X_RST;
      pos_y_q  <= Y_RST;
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      colour_q <= '0;
      plot_q   <= 1'b0;
      x_out_q  <= X_RST;
      y_out_q  <= Y_RST;
    end else if (accept) begin
      unique case (op)
        OP_DRAW, OP_ERASE: begin
          colour_q <= (op == OP_DRAW) ? colour_in : BG;
          plot_q   <= 1'b1;
          x_out_q  <= pos_x_q;
          y_out_q  <= pos_y_q;
        end
        OP_STEP: begin
          dir_x_q <= ndir_x;
          dir_y_q <= ndir_y;
          pos_x_q <= step_x;
          pos_y_q <= step_y;
        end
        OP_SET: begin
          pos_x_q <= set_x;
          pos_y_q <= set_y;
        end
      endcase
    end else if (scanning) begin
      if (last_px) begin
        plot_q <= 1'b0;
      end else begin
        x_out_q <= nxt_x;
        y_out_q <= nxt_y;
      end
    end
  end

  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour_out = colour_q;
  assign plot       = plot_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Scoreboard bench for sprite_blit_engine: directed and random
// commands against a reference model, plus a resized instance.
module tb_sprite_blit_engine;

  localparam int SW = 160;
  localparam int SH = 120;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int SW2 = 64;
  localparam int W2  = 8;
  localparam int H2  = 2;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0;
  logic [1:0] op = 2'd0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [2:0] colour_in = '0;
  logic [7:0] x_out, pos_x;
  logic [6:0] y_out, pos_y;
  logic [2:0] colour_out;
  logic       plot, busy, done;

  logic       go2 = 1'b0;
  logic [1:0] op2 = 2'd0;
  logic [7:0] x_out2, pos_x2;
  logic [6:0] y_out2, pos_y2;
  logic [2:0] colour_out2;
  logic       plot2, busy2, done2;

  always #5 clock = ~clock;

  sprite_blit_engine dut (
    .clock(clock), .resetn(resetn), .go(go), .op(op),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot(plot), .busy(busy), .done(done),
    .pos_x(pos_x), .pos_y(pos_y)
  );

  sprite_blit_engine #(
    .SPRITE_W(W2), .SPRITE_H(H2), .SCREEN_W(SW2)
  ) dut2 (
    .clock(clock), .resetn(resetn), .go(go2), .op(op2),
    .x_in(8'd0), .y_in(7'd0), .colour_in(3'd1),
    .x_out(x_out2), .y_out(y_out2), .colour_out(colour_out2),
    .plot(plot2), .busy(busy2), .done(done2),
    .pos_x(pos_x2), .pos_y(pos_y2)
  );

  typedef struct { int x; int y; int c; } px_t;
  px_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int nplot = 0;
  int nplot2 = 0;
  int mx, my, mdx, mdy;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (resetn && plot) begin
      nplot++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d expected none",
                 x_out, y_out);
      end else begin
        px_t e;
        e = exp_q.pop_front();
        check("px_x", int'(x_out), e.x);
        check("px_y", int'(y_out), e.y);
        check("px_colour", int'(colour_out), e.c);
      end
    end
    if (resetn && plot2) nplot2++;
  end

  task automatic model_reset();
    mx = 0; my = 60; mdx = 1; mdy = 1;
  endtask

  function automatic int bounce(input int p, inout int d, input int maxp);
    if (d == 1 && p == maxp) d = -1;
    else if (d == -1 && p == 0) d = 1;
    return p + d;
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_cmd(input logic [1:0] o, input int xi, input int yi,
                         input int ci, input bit inject);
    int n, busy_n, p0, col;
    px_t e;
    bit is_scan;
    n = 0;
    while (busy && n < 100) begin @(negedge clock); n++; end
    is_scan = (o == 2'd0) || (o == 2'd1);
    op = o; x_in = 8'(xi); y_in = 7'(yi); colour_in = 3'(ci); go = 1'b1;
    if (is_scan) begin
      col = (o == 2'd0) ? ci : 0;
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          e.x = mx + c; e.y = my + r; e.c = col;
          exp_q.push_back(e);
        end
    end else if (o == 2'd2) begin
      mx = bounce(mx, mdx, SW - W);
      my = bounce(my, mdy, SH - H);
    end else begin
      mx = (xi > SW - W) ? SW - W : xi;
      my = (yi > SH - H) ? SH - H : yi;
    end
    p0 = nplot;
    @(posedge clock);
    #1 go = 1'b0;
    n = 0; busy_n = 0;
    do begin
      @(negedge clock);
      n++;
      if (busy) busy_n++;
      if (inject && n == 5) begin
        go = 1'b1; op = 2'($urandom_range(0, 3));
        x_in = 8'($urandom_range(0, 255));
      end
      if (n == 6) go = 1'b0;
    end while (!done && n < 100);
    check("done_latency", n, is_scan ? W * H + 1 : 1);
    check("busy_cycles", busy_n, is_scan ? W * H : 0);
    check("plot_count", nplot - p0, is_scan ? W * H : 0);
    check("pos_x", int'(pos_x), mx);
    check("pos_y", int'(pos_y), my);
  endtask

  task automatic run_cmd2(input logic [1:0] o);
    int n;
    @(negedge clock);
    n = 0;
    while (busy2 && n < 100) begin @(negedge clock); n++; end
    op2 = o; go2 = 1'b1;
    @(posedge clock);
    #1 go2 = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!done2 && n < 100);
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL sweep_done_timeout: got none expected done");
    end
  endtask

  initial begin
    int mx2, my2, dx2, dy2, hit_hi, hit_lo, p;
    model_reset();

    repeat (3) @(negedge clock);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pos_y", int'(pos_y), 60);
    resetn = 1'b1;
    @(negedge clock);
    check("rel_pos_x", int'(pos_x), 0);
    check("rel_pos_y", int'(pos_y), 60);
    check("rel_x_out", int'(x_out), 0);
    check("rel_y_out", int'(y_out), 60);
    check("rel_colour", int'(colour_out), 0);
    check("rel_done", int'(done), 0);

    run_cmd(2'd0, 0, 0, 5, 1'b0);
    run_cmd(2'd3, 200, 100, 0, 1'b0);
    run_cmd(2'd2, 0, 0, 0, 1'b0);
    run_cmd(2'd3, 0, 0, 0, 1'b0);
    run_cmd(2'd2, 0, 0, 0, 1'b0);
    run_cmd(2'd0, 0, 0, 6, 1'b0);
    run_cmd(2'd1, 0, 0, 6, 1'b1);

    // Abort a DRAW part-way with reset.
    run_cmd(2'd3, 30, 20, 0, 1'b0);
    op = 2'd0; colour_in = 3'd7; go = 1'b1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_q.push_back('{x: mx + c, y: my + r, c: 7});
    @(posedge clock);
    #1 go = 1'b0;
    repeat (7) @(negedge clock);
    #1 resetn = 1'b0;
    #1;
    check("abort_plot", int'(plot), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_pos_x", int'(pos_x), 0);
    check("abort_pos_y", int'(pos_y), 60);
    check("abort_y_out", int'(y_out), 60);
    exp_q.delete();
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    run_cmd(2'd0, 0, 0, 2, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 127)), int'($urandom_range(0, 7)),
              ($urandom_range(0, 3) == 0));
    end
    check("queue_empty", exp_q.size(), 0);

    mx2 = 0; my2 = 60; dx2 = 1; dy2 = 1; hit_hi = 0; hit_lo = 0;
    for (int i = 0; i < 130; i++) begin
      run_cmd2(2'd2);
      mx2 = bounce(mx2, dx2, SW2 - W2);
      my2 = bounce(my2, dy2, SH - H2);
      check("sweep_pos_x", int'(pos_x2), mx2);
      check("sweep_pos_y", int'(pos_y2), my2);
      if (pos_x2 == 8'(SW2 - W2)) hit_hi++;
      if (pos_x2 == 8'd0) hit_lo++;
    end
    check("sweep_hit_right", hit_hi, 1);
    check("sweep_hit_left", hit_lo, 1);
    p = nplot2;
    run_cmd2(2'd0);
    check("sweep_plots", nplot2 - p, W2 * H2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
